// File: rtl/rv_pkg.sv
// Shared definitions for the operand fetch path: widths, FSM encoding and
// the write-back compare used by both capture and snoop.
package rv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2,
        DONE
    } opf_state_t;

    // Write-back targets this (non-zero) register index.
    function automatic logic wb_hits(
        input logic                 wb_write,
        input logic [REG_IDX_W-1:0] wb_num,
        input logic [REG_IDX_W-1:0] idx
    );
        return wb_write && (wb_num == idx) && (idx != ZERO_REG);
    endfunction

    // A write to x0 clears the entire register file.
    function automatic logic wb_clears(
        input logic                 wb_write,
        input logic [REG_IDX_W-1:0] wb_num
    );
        return wb_write && (wb_num == ZERO_REG);
    endfunction

endpackage

// File: rtl/operand_select.sv
// Capture mux: resolves the value of one register index against the current
// register-file read data and the in-flight write-back.
module operand_select
    import rv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [W-1:0]         rf_data,
    input  logic                 wb_write,
    input  logic [REG_IDX_W-1:0] wb_num,
    input  logic [W-1:0]         wb_data,
    output logic [W-1:0]         value
);

    // x0 and a same-cycle clear read as zero; a matching write bypasses the file.
    always_comb begin
        value = rf_data;
        if (idx == ZERO_REG || wb_clears(wb_write, wb_num)) begin
            value = '0;
        end else if (wb_hits(wb_write, wb_num, idx)) begin
            value = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads rs1 then rs2 through the single register-file
// read port and holds the pair (kept coherent with write-back) until consumed.
//
// state | meaning
// IDLE  | waiting for a decode request, in_ready high
// RD1   | readnum = rs1, capturing rs1 value
// RD2   | readnum = rs2, capturing rs2 value
// DONE  | operand pair valid, waiting for execute to consume
module operand_fetch
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int META_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic                 in_use_rs2,
    input  logic [META_W-1:0]    in_meta,
    output logic [REG_IDX_W-1:0] readnum,
    input  logic [XLEN-1:0]      rf_data,
    input  logic                 wb_write,
    input  logic [REG_IDX_W-1:0] wb_num,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [META_W-1:0]    out_meta
);

    opf_state_t           state_q, state_d;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d;
    logic [REG_IDX_W-1:0] rs2_q, rs2_d;
    logic                 use_rs2_q, use_rs2_d;
    logic [META_W-1:0]    meta_q, meta_d;
    logic [XLEN-1:0]      rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]      rs2_val_q, rs2_val_d;
    logic [XLEN-1:0]      cap_val;
    logic                 accept;
    logic                 wb_clr;

    assign in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid && in_ready;
    assign wb_clr      = wb_clears(wb_write, wb_num);
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_meta    = meta_q;

    // Read port index follows the state; parked at x0 when not reading.
    always_comb begin
        readnum = ZERO_REG;
        case (state_q)
            RD1:     readnum = rs1_q;
            RD2:     readnum = rs2_q;
            default: readnum = ZERO_REG;
        endcase
    end

    operand_select #(.W(XLEN)) u_capture (
        .idx      (readnum),
        .rf_data  (rf_data),
        .wb_write (wb_write),
        .wb_num   (wb_num),
        .wb_data  (wb_data),
        .value    (cap_val)
    );

    // Next-state, request latch, capture and snoop of held operands.
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_rs2_d = use_rs2_q;
        meta_d    = meta_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = RD1;
            end
            RD1: begin
                rs1_val_d = cap_val;
                if (use_rs2_q) begin
                    state_d = RD2;
                end else begin
                    rs2_val_d = '0;
                    state_d   = DONE;
                end
            end
            RD2: begin
                rs2_val_d = cap_val;
                if (wb_clr) rs1_val_d = '0;
                else if (wb_hits(wb_write, wb_num, rs1_q)) rs1_val_d = wb_data;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    // Departing pair is delivered this cycle; no snoop needed.
                    state_d = accept ? RD1 : IDLE;
                end else begin
                    if (wb_clr) begin
                        rs1_val_d = '0;
                        rs2_val_d = '0;
                    end else begin
                        if (wb_hits(wb_write, wb_num, rs1_q)) rs1_val_d = wb_data;
                        if (use_rs2_q && wb_hits(wb_write, wb_num, rs2_q)) rs2_val_d = wb_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            use_rs2_d = in_use_rs2;
            meta_d    = in_meta;
        end
    end

    // State and operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rs1_q     <= ZERO_REG;
            rs2_q     <= ZERO_REG;
            use_rs2_q <= 1'b0;
            meta_q    <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_rs2_q <= use_rs2_d;
            meta_q    <= meta_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file, scoreboard of expected
// operand pairs checked at each output handshake, plus directed cycle checks.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs2;
    logic [31:0] in_meta;
    logic [4:0]  readnum;
    logic [31:0] rf_data;
    logic        wb_write;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_meta;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] meta;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] rf [32];
    logic        rf_force;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32), .META_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_use_rs2  (in_use_rs2),
        .in_meta     (in_meta),
        .readnum     (readnum),
        .rf_data     (rf_data),
        .wb_write    (wb_write),
        .wb_num      (wb_num),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_meta    (out_meta)
    );

    // Register file model: combinational read, write at the edge, x0 write clears all.
    assign rf_data = rf_force ? 32'hFFFF_FFFF : rf[readnum];

    always @(posedge clk) begin
        if (reset || (wb_write && wb_num == 5'd0)) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (wb_write) begin
            rf[wb_num] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest expected pair.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {63'b0, out_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_rs1", {32'b0, out_rs1_val}, {32'b0, mon_e.r1});
                check("sb_rs2", {32'b0, out_rs2_val}, {32'b0, mon_e.r2});
                check("sb_meta", {32'b0, out_meta}, {32'b0, mon_e.meta});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] idx, input logic [31:0] val);
        wb_write = 1'b1;
        wb_num   = idx;
        wb_data  = val;
        step();
        wb_write = 1'b0;
    endtask

    task automatic request(input logic [4:0] r1, input logic [4:0] r2,
                           input logic use2, input logic [31:0] meta);
        in_valid   = 1'b1;
        in_rs1     = r1;
        in_rs2     = r2;
        in_use_rs2 = use2;
        in_meta    = meta;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_rs2 = 1'b0;
        in_meta    = '0;
        wb_write   = 1'b0;
        wb_num     = '0;
        wb_data    = '0;
        out_ready  = 1'b0;
        rf_force   = 1'b0;
        step();
        step();

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_readnum", {59'b0, readnum}, 64'd0);
        check("rst_rs1", {32'b0, out_rs1_val}, 64'd0);
        check("rst_rs2", {32'b0, out_rs2_val}, 64'd0);
        check("rst_meta", {32'b0, out_meta}, 64'd0);
        step();
        reset = 1'b0;

        rf_write(5'd5, 32'h11);
        rf_write(5'd6, 32'h22);
        rf_write(5'd7, 32'h1234);

        // Two-operand read with stall
        request(5'd5, 5'd6, 1'b1, 32'hA0A0_0001);
        sb.push_back('{32'h11, 32'h22, 32'hA0A0_0001});
        @(negedge clk);
        check("t2_in_ready", {63'b0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_readnum_rs1", {59'b0, readnum}, 64'd5);
        check("t2_valid_rd1", {63'b0, out_valid}, 64'd0);
        step();
        @(negedge clk);
        check("t2_readnum_rs2", {59'b0, readnum}, 64'd6);
        check("t2_valid_rd2", {63'b0, out_valid}, 64'd0);
        step();
        @(negedge clk);
        check("t2_valid_done", {63'b0, out_valid}, 64'd1);
        check("t2_readnum_done", {59'b0, readnum}, 64'd0);
        check("t2_in_ready_stall", {63'b0, in_ready}, 64'd0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t2_idle_valid", {63'b0, out_valid}, 64'd0);

        // Same-cycle write-back bypass on rs1 capture
        request(5'd7, 5'd0, 1'b0, 32'hB0B0_0002);
        sb.push_back('{32'hDEAD, 32'h0, 32'hB0B0_0002});
        step();
        in_valid = 1'b0;
        wb_write = 1'b1;
        wb_num   = 5'd7;
        wb_data  = 32'hDEAD;
        @(negedge clk);
        check("t3_readnum", {59'b0, readnum}, 64'd7);
        step();
        wb_write  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_t2", {63'b0, out_valid}, 64'd1);
        step();
        out_ready = 1'b0;

        // x0 read with forced read data, single operand
        rf_force = 1'b1;
        request(5'd0, 5'd3, 1'b0, 32'hC0C0_0003);
        sb.push_back('{32'h0, 32'h0, 32'hC0C0_0003});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_rd1", {63'b0, out_valid}, 64'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_t2", {63'b0, out_valid}, 64'd1);
        step();
        out_ready = 1'b0;
        rf_force  = 1'b0;

        // Stall in DONE with snoop writes, then x0 clear
        request(5'd5, 5'd6, 1'b1, 32'hD0D0_0004);
        sb.push_back('{32'h0, 32'h0, 32'hD0D0_0004});
        step();
        in_valid = 1'b0;
        step();
        step();
        wb_write = 1'b1;
        wb_num   = 5'd6;
        wb_data  = 32'h99;
        @(negedge clk);
        check("t5_valid", {63'b0, out_valid}, 64'd1);
        check("t5_rs2_before", {32'b0, out_rs2_val}, 64'h22);
        step();
        wb_num  = 5'd0;
        wb_data = 32'h5A;
        @(negedge clk);
        check("t5_rs2_snoop", {32'b0, out_rs2_val}, 64'h99);
        check("t5_rs1_hold", {32'b0, out_rs1_val}, 64'h11);
        step();
        wb_write = 1'b0;
        @(negedge clk);
        check("t5_rs1_clr", {32'b0, out_rs1_val}, 64'h0);
        check("t5_rs2_clr", {32'b0, out_rs2_val}, 64'h0);
        check("t5_valid_hold", {63'b0, out_valid}, 64'd1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        rf_write(5'd5, 32'h11);
        rf_write(5'd6, 32'h22);
        rf_write(5'd9, 32'h99);

        // Back-to-back with a snoop write in the handoff cycle
        out_ready = 1'b1;
        request(5'd5, 5'd6, 1'b1, 32'hE0E0_0005);
        sb.push_back('{32'h11, 32'h22, 32'hE0E0_0005});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_c1_valid", {63'b0, out_valid}, 64'd0);
        step();
        @(negedge clk);
        check("t6_c2_valid", {63'b0, out_valid}, 64'd0);
        step();
        request(5'd5, 5'd9, 1'b1, 32'hE0E0_0006);
        sb.push_back('{32'h555, 32'h99, 32'hE0E0_0006});
        wb_write = 1'b1;
        wb_num   = 5'd5;
        wb_data  = 32'h555;
        @(negedge clk);
        check("t6_c3_valid", {63'b0, out_valid}, 64'd1);
        check("t6_c3_in_ready", {63'b0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        wb_write = 1'b0;
        @(negedge clk);
        check("t6_c4_valid", {63'b0, out_valid}, 64'd0);
        check("t6_c4_readnum", {59'b0, readnum}, 64'd5);
        step();
        @(negedge clk);
        check("t6_c5_valid", {63'b0, out_valid}, 64'd0);
        check("t6_c5_readnum", {59'b0, readnum}, 64'd9);
        step();
        @(negedge clk);
        check("t6_c6_valid", {63'b0, out_valid}, 64'd1);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t6_c7_valid", {63'b0, out_valid}, 64'd0);

        // Reset while in RD2 aborts the request
        request(5'd5, 5'd6, 1'b1, 32'hF0F0_0007);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("t7_readnum_rd2", {59'b0, readnum}, 64'd6);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t7_in_ready", {63'b0, in_ready}, 64'd1);
        check("t7_valid", {63'b0, out_valid}, 64'd0);
        check("t7_readnum", {59'b0, readnum}, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("t7_no_output", {63'b0, out_valid}, 64'd0);
        end
        out_ready = 1'b0;

        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Sequencer between instruction decode and the single-read-port register file. Accepts a decoded source-register request over a valid/ready handshake and drives the register file's `readnum` for rs1, then rs2, over consecutive cycles. Captures each value with same-cycle write-back bypass and holds the operand pair for the execute stage until it is consumed. Held operands track later register-file writes until handoff.

## Interface
- `XLEN`, 32: operand and register width.
- `META_W`, 32: width of the opaque sideband (pc/imm/op bits) passed through unchanged.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decode request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_rs1` in 5: first source register index.
- `in_rs2` in 5: second source register index.
- `in_use_rs2` in 1: 0 means a single-operand instruction; the rs2 read is skipped.
- `in_meta` in META_W: sideband, latched on accept.
- `readnum` out 5: drives the register file read index.
- `rf_data` in XLEN: combinational read data from the register file.
- `wb_write` in 1: write strobe, shared with the register file's `write`.
- `wb_num` in 5: write index, shared with the register file's `writenum`.
- `wb_data` in XLEN: write data, shared with the register file's `data_in`.
- `out_valid` out 1: operand pair valid.
- `out_ready` in 1: execute stage consumes when `out_valid && out_ready`.
- `out_rs1_val` out XLEN: rs1 value.
- `out_rs2_val` out XLEN: rs2 value; 0 when `in_use_rs2` was 0.
- `out_meta` out META_W: latched sideband.

## Operation
- **States**
  - `IDLE`: `in_ready`=1, `readnum`=0.
  - `RD1`: `readnum`=rs1_q; captures the rs1 value.
  - `RD2`: `readnum`=rs2_q; captures the rs2 value.
  - `DONE`: `out_valid`=1, `readnum`=0.
- **Transitions**
  - `IDLE` → `RD1` on accept; latch rs1, rs2, use_rs2 and meta.
  - `RD1` → `RD2` if use_rs2_q, else → `DONE` with rs2 value forced to 0.
  - `RD2` → `DONE`.
  - `DONE`: if `out_ready` and `in_valid`, accept the new request and go → `RD1` (back-to-back). If `out_ready` only, go → `IDLE`. Otherwise hold.
- **`in_ready`** = (state==`IDLE`) || (state==`DONE` && `out_ready`).
- **Capture value for index i**, in priority order:
  - i==0 → 0.
  - `wb_write` && `wb_num`==i → `wb_data` (bypass; the register file updates only at the edge).
  - otherwise `rf_data`.
- **Snoop**
  - Applies to any already-captured, undelivered operand, including in `DONE` while stalled.
  - `wb_write` with `wb_num`==its index (≠0) replaces the held value with `wb_data` at the edge.
- **Write to index 0** (`wb_write` && `wb_num`==0): the register file clears every register. Therefore:
  - all held operand values clear to 0 at that edge;
  - a capture in that same cycle yields 0.
- **Reset mid-operation**: the in-flight request is discarded; no output handshake occurs.

## Timing
- **Reset values**:
  - state `IDLE`, `in_ready`=1, `out_valid`=0, `readnum`=0;
  - `out_rs1_val`=0, `out_rs2_val`=0, `out_meta`=0.
- **Latency**, with accept at edge T:
  - `RD1` during cycle T+1; `out_valid` from T+2 for one-operand requests.
  - Two-operand requests: `RD2` during T+2; `out_valid` from T+3.
- **Throughput**, with `out_ready` held high: one two-operand request per 3 cycles, or one single-operand request per 2 cycles.
- **Output stability**: while `out_valid`=1 && !`out_ready`, the outputs are stable except for snoop updates.
- **Simultaneous events**: a snoop write and a back-to-back accept in `DONE` in the same cycle. The departing operands are delivered before the write; the new request's capture in `RD1` sees the write via `rf_data`.

## Structure
- **Shared package `rv_pkg`**:
  - `XLEN` and `REG_IDX_W`=5;
  - `typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} opf_state_t`;
  - a `ZERO_REG` constant.
- **Sub-module `operand_select`**: combinational capture/bypass mux (index, `rf_data`, wb bus → value). Instantiate it once for capture. Snoop logic reuses the same compare.

## Test plan
- **Two-operand read**: X5=0x11, X6=0x22; request rs1=5, rs2=6 → `readnum` 5 then 6; `out_valid` at T+3 with 0x11/0x22.
- **Bypass**: in `RD1` for rs1=7, wb writes X7=0xDEAD in the same cycle → `out_rs1_val`=0xDEAD, not the old value.
- **x0 and single-operand**: X0 read with `rf_data` forced to 0xFFFF_FFFF, `in_use_rs2`=0 → `out_rs1_val`=0, `out_rs2_val`=0, `out_valid` at T+2.
- **Stall and snoop**: hold `out_ready`=0 in `DONE` for 3 cycles and write X6=0x99 → `out_rs2_val` becomes 0x99. Then wb_num=0 write → both values 0.
- **Back-to-back**: two requests with `out_ready`=1 → second accepted in the `DONE` cycle; `out_valid` pulses exactly once per request, 3 cycles apart.
- **Reset mid-operation**: assert `reset` in `RD2` → next cycle `IDLE`, `out_valid`=0, `readnum`=0; no output for the aborted request.
